// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake to
// instruction memory, and drives the IF/ID register with a one-entry hold
// buffer so a decode freeze never loses a returned word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | request for fetch_pc outstanding (or about to be issued)
// HOLD    | fetched word parked in hold buffer while decode is frozen
// DISCARD | stale request still in flight after a branch; its word is dropped
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instruction
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   // Branch target waiting for the stale request to retire. Keeping it apart
   // from fetch_pc lets imem_addr stay stable until the old request is acked.
   logic [31:0] redirect_pc, redirect_pc_nxt;
   logic [31:0] hold_pc, hold_pc_nxt;
   logic [31:0] hold_instr, hold_instr_nxt;
   logic [31:0] pc_nxt, instruction_nxt;

   logic        ack;
   logic [31:0] target;
   logic [31:0] pc_inc;

   assign imem_req  = rst & (state != HOLD);
   assign imem_addr = fetch_pc;
   assign ack       = imem_ack & imem_req;
   assign target    = branch_addr & 32'hFFFF_FFFC;
   assign pc_inc    = fetch_pc + 32'd4;

   // Next-state, fetch-address and IF/ID update selection.
   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      redirect_pc_nxt = redirect_pc;
      hold_pc_nxt     = hold_pc;
      hold_instr_nxt  = hold_instr;
      pc_nxt          = pc;
      instruction_nxt = instruction;

      if (branch_taken) begin
         pc_nxt          = 32'h0;
         instruction_nxt = 32'h0;
         hold_pc_nxt     = 32'h0;
         hold_instr_nxt  = 32'h0;
         case (state)
            FETCH: begin
               if (ack) begin
                  fetch_pc_nxt = target;
               end else begin
                  redirect_pc_nxt = target;
                  state_nxt       = DISCARD;
               end
            end
            HOLD: begin
               fetch_pc_nxt = target;
               state_nxt    = FETCH;
            end
            DISCARD: begin
               redirect_pc_nxt = target;
               if (ack) begin
                  fetch_pc_nxt = target;
                  state_nxt    = FETCH;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (ack) begin
                  fetch_pc_nxt = pc_inc;
                  if (freeze) begin
                     hold_pc_nxt    = pc_inc;
                     hold_instr_nxt = imem_rdata;
                     state_nxt      = HOLD;
                  end else begin
                     pc_nxt          = pc_inc;
                     instruction_nxt = imem_rdata;
                  end
               end else if (!freeze) begin
                  pc_nxt          = 32'h0;
                  instruction_nxt = 32'h0;
               end
            end
            HOLD: begin
               if (!freeze) begin
                  pc_nxt          = hold_pc;
                  instruction_nxt = hold_instr;
                  state_nxt       = FETCH;
               end
            end
            DISCARD: begin
               if (!freeze) begin
                  pc_nxt          = 32'h0;
                  instruction_nxt = 32'h0;
               end
               if (ack) begin
                  fetch_pc_nxt = redirect_pc;
                  state_nxt    = FETCH;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         redirect_pc <= 32'h0;
         hold_pc     <= 32'h0;
         hold_instr  <= 32'h0;
         pc          <= 32'h0;
         instruction <= 32'h0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         redirect_pc <= redirect_pc_nxt;
         hold_pc     <= hold_pc_nxt;
         hold_instr  <= hold_instr_nxt;
         pc          <= pc_nxt;
         instruction <= instruction_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed bring-up steps followed by random
// freeze/branch/ack/reset traffic compared against a transaction-level model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] pc;
   logic [31:0] instruction;

   int total = 0;
   int bad   = 0;

   if_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .instruction  (instruction)
   );

   always #5 clk = ~clk;

   // Reference model: what the decode stage should see and what is in flight.
   logic        m_valid = 1'b0;   // model meaningful once a reset edge has occurred
   logic [31:0] m_addr;           // address the memory is being asked for
   logic        m_stale;          // in-flight request belongs to a squashed path
   logic [31:0] m_target;         // where fetching resumes after the stale word
   logic        m_parked;         // a fetched word is waiting out a freeze
   logic [31:0] m_park_pc, m_park_instr;
   logic [31:0] m_pc, m_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hE080_0002;
      if (a == 32'h4) return 32'hE241_1001;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: starts and ends at a falling edge.
   task automatic step(input logic r, input logic f, input logic b,
                       input logic [31:0] ba, input logic a);
      logic        req_exp;
      logic        got;
      logic [31:0] tgt;
      logic [31:0] word;
      if (m_valid) begin
         check("pc", pc, m_pc);
         check("instruction", instruction, m_instr);
         check("imem_addr", imem_addr, m_addr);
      end
      rst          = r;
      freeze       = f;
      branch_taken = b;
      branch_addr  = ba;
      imem_ack     = a;
      imem_rdata   = mem_word(imem_addr);
      #1;
      req_exp = r && !m_parked;
      if (!m_valid) req_exp = 1'b0;
      if (r && m_valid) check("imem_req", {31'h0, imem_req}, {31'h0, req_exp});
      if (!r) check("imem_req_rst", {31'h0, imem_req}, 32'h0);

      got  = a && req_exp;
      tgt  = {ba[31:2], 2'b00};
      word = mem_word(m_addr);
      if (!r) begin
         m_valid  = 1'b1;
         m_addr   = 32'h0;
         m_stale  = 1'b0;
         m_target = 32'h0;
         m_parked = 1'b0;
         m_pc     = 32'h0;
         m_instr  = 32'h0;
      end else if (m_valid) begin
         if (b) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            if (m_parked) begin
               m_parked = 1'b0;
               m_addr   = tgt;
            end else if (m_stale || !got) begin
               m_target = tgt;
               m_stale  = !got;
               if (got) m_addr = tgt;
            end else begin
               m_addr = tgt;
            end
         end else if (m_stale) begin
            if (!f) begin m_pc = 32'h0; m_instr = 32'h0; end
            if (got) begin m_stale = 1'b0; m_addr = m_target; end
         end else if (m_parked) begin
            if (!f) begin
               m_pc     = m_park_pc;
               m_instr  = m_park_instr;
               m_parked = 1'b0;
            end
         end else if (got) begin
            if (f) begin
               m_parked     = 1'b1;
               m_park_pc    = m_addr + 32'd4;
               m_park_instr = word;
            end else begin
               m_pc    = m_addr + 32'd4;
               m_instr = word;
            end
            m_addr = m_addr + 32'd4;
         end else if (!f) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic        r, f, b, a;
      logic [31:0] ba;
      int unsigned sel;
      @(negedge clk);

      // Reset for two cycles, then zero-wait streaming.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("reset_pc", pc, 32'h0);
      check("reset_instr", instruction, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("stream0_pc", pc, 32'h4);
      check("stream0_instr", instruction, 32'hE080_0002);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("stream1_pc", pc, 32'h8);
      check("stream1_instr", instruction, 32'hE241_1001);

      // Three wait cycles on address 8.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         check("wait_bubble", instruction, 32'h0);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("wait_pc", pc, 32'd12);

      // Branch plus freeze with an unaligned target, then wrap at the top.
      step(1'b1, 1'b1, 1'b1, 32'h43, 1'b1);
      check("bf_flush", instruction, 32'h0);
      check("bf_addr", imem_addr, 32'h40);
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("wrap_pc", pc, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 99) >= 2);
         f = ($urandom_range(0, 99) < 30);
         b = ($urandom_range(0, 99) < 8);
         a = ($urandom_range(0, 99) < 50);
         sel = $urandom_range(0, 3);
         case (sel)
            0:       ba = 32'hFFFF_FFF8;
            1:       ba = 32'hFFFF_FFFB;
            2:       ba = 32'h0000_0043;
            default: ba = $urandom;
         endcase
         step(r, f, b, ba, a);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined ARM core, driving the `pc`/`instruction` pair consumed by the decode stage. It owns the fetch PC and runs a req/ack handshake to a variable-latency instruction memory. It includes the IF/ID pipeline register and a one-entry hold buffer, so a decode freeze never loses a fetched word. Pipeline bubbles are emitted as the all-zero instruction, which decode treats as a NOP.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-low reset.
- `freeze`  input  1: decode hazard stall; hold IF/ID contents.
- `branch_taken`  input  1: taken branch from execute; flush and redirect.
- `branch_addr`  input  32: branch target; bits [1:0] are ignored and treated as 0.
- `imem_req`  output  1: fetch request to instruction memory.
- `imem_addr`  output  32: word-aligned fetch address.
- `imem_ack`  input  1: memory response; meaningful only while `imem_req` is 1.
- `imem_rdata`  input  32: instruction word; valid in the cycle `imem_ack` is 1.
- `pc`  output  32: fetch address + 4 of the presented instruction (registered).
- `instruction`  output  32: presented instruction; 32'h0 means bubble (registered).

## Operation

- Internal state:
  - `fetch_pc` (32 bits).
  - Hold buffer: `hold_pc`, `hold_instr`.
  - FSM states: FETCH, HOLD, DISCARD.
- Request behaviour:
  - `imem_req` = 1 in FETCH and DISCARD, and 0 in HOLD.
  - `imem_req` is forced to 0 while `rst` is 0.
  - `imem_addr` = `fetch_pc` at all times.
  - While `imem_req` = 1 and no ack has arrived, `imem_addr` holds stable.
- Reset (`rst` = 0 at an edge):
  - `fetch_pc` ← `RESET_PC`; `pc` ← 0; `instruction` ← 0.
  - Hold buffer ← 0; state ← FETCH.
- Priority per edge, highest first: reset, `branch_taken`, `freeze`, normal flow.
- `branch_taken` = 1, in any state, regardless of `freeze`:
  - Flush: `pc` ← 0, `instruction` ← 0.
  - `fetch_pc` ← {`branch_addr`[31:2], 2'b00}.
  - FETCH with `imem_ack` = 0: go to DISCARD, because the old request must still complete.
  - FETCH with `imem_ack` = 1: drop the returned word and stay in FETCH.
  - HOLD: drop the buffer and go to FETCH.
  - DISCARD: update the target only; go to FETCH if `imem_ack` = 1, otherwise stay in DISCARD.
- `freeze` = 1 (no branch): IF/ID holds its value.
  - FETCH with ack: `hold_pc` ← `fetch_pc`+4, `hold_instr` ← `imem_rdata`, `fetch_pc` += 4, go to HOLD.
  - FETCH without ack: no change.
  - HOLD: stay in HOLD.
  - DISCARD with ack: go to FETCH (returned word dropped).
  - DISCARD without ack: stay in DISCARD.
- Normal flow (`freeze` = 0, no branch):
  - FETCH with ack: `pc` ← `fetch_pc`+4, `instruction` ← `imem_rdata`, `fetch_pc` += 4, stay in FETCH.
  - FETCH without ack: IF/ID ← bubble (0, 0).
  - HOLD: IF/ID ← (`hold_pc`, `hold_instr`); go to FETCH. The request for `fetch_pc` restarts in the next cycle.
  - DISCARD: IF/ID ← bubble; go to FETCH on ack.
- Arithmetic: all +4 operations are 32-bit modulo. Address 32'hFFFF_FFFC wraps to 0.
- Words returned by a request in DISCARD are never presented.

## Timing

- With zero-wait memory (`imem_ack` tied to 1), throughput is one instruction per cycle.
  - A word acked at edge N is visible on `pc`/`instruction` after edge N.
- First request: `imem_req` rises in the first cycle with `rst` = 1, with `imem_addr` = `RESET_PC`.
- With W wait cycles, the IF/ID output shows W bubbles followed by one valid cycle.
- Branch penalty:
  - The flush takes effect at the branch edge.
  - The target request is issued in the next cycle, or after the outstanding ack arrives.
- Leaving HOLD costs one cycle:
  - The buffered word is presented at the edge where `freeze` falls.
  - The next request is issued in the following cycle.
- Reset mid-request: the memory must tolerate `imem_req` dropping without an ack. The fetch unit ignores any ack that arrives while `rst` = 0.

## Test plan

1. Reset: `rst` = 0 for 2 cycles, `RESET_PC` = 0 → `pc` = 0, `instruction` = 0, `imem_req` = 0. After release: `imem_req` = 1, `imem_addr` = 0.
2. Streaming: `imem_ack` tied to 1, memory returns 32'hE080_0002 at address 0 and 32'hE241_1001 at address 4 → outputs (pc 4, E0800002), then (pc 8, E2411001) on consecutive cycles.
3. Wait states: ack arrives 3 cycles after the request for address 8 → `imem_addr` = 8 for all 3 cycles, `instruction` = 0 for 3 cycles, then (pc 12, word) for exactly 1 cycle.
4. Freeze capture:
   - Stimulus: `freeze` = 1 when the ack for address 8 arrives, held 4 cycles.
   - Response: IF/ID holds (pc 8, previous word) and `imem_req` = 0.
   - When `freeze` falls: (pc 12, word at address 8) is presented, and the next request has `imem_addr` = 12.
5. Branch during an outstanding request:
   - Stimulus: request to 32'h10 pending, `branch_taken` pulse with `branch_addr` = 32'h40.
   - Response: `instruction` → 0; `imem_addr` stays 32'h10 until the ack; that word is never presented; the next `imem_addr` = 32'h40.
6. Branch plus freeze in the same cycle, `branch_addr` = 32'h43 → the flush happens and the next fetch is at 32'h40. Separately, `fetch_pc` = 32'hFFFF_FFFC with an ack → `pc` = 0 and the next `imem_addr` = 0.
